// File: rtl/idct_pkg.sv
// Shared types and helpers for the IDCT datapath.
//   WORD_W / BLOCK_SIZE / IDX_W : word width, samples per 8x8 block, raster index width
//   idct_word_t                 : one signed IDCT coefficient/sample
//   idct_block_t                : all 64 samples of a block, element [i] is raster index i
//   unloader_state_e            : state of the output-side unloader
//   pixel_clamp()               : JPEG level shift (+128) and clamp to an 8-bit pixel
package idct_pkg;

  localparam int unsigned WORD_W     = 16;
  localparam int unsigned BLOCK_SIZE = 64;
  localparam int unsigned IDX_W      = 6;

  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(BLOCK_SIZE - 1);

  typedef logic signed [WORD_W-1:0] idct_word_t;
  typedef logic [BLOCK_SIZE-1:0][WORD_W-1:0] idct_block_t;

  typedef enum logic [0:0] {
    StIdle,
    StStream
  } unloader_state_e;

  // One extra bit of headroom so that in+128 can never wrap.
  function automatic logic [7:0] pixel_clamp(input idct_word_t w);
    logic signed [WORD_W:0] s;
    s = $signed({w[WORD_W-1], w}) + 17'sd128;
    if (s < 17'sd0) begin
      return 8'h00;
    end else if (s > 17'sd255) begin
      return 8'hff;
    end else begin
      return s[7:0];
    end
  endfunction

endpackage

// File: rtl/idct_latency_tracker.sv
// Fixed-latency block tracker.
// A LATENCY-deep shift register samples in_start every edge; emerge is its tail, so it is
// high exactly during the cycle whose closing edge is LATENCY edges after in_start was
// sampled.
//   clk      : clock, rising edge
//   rst      : asynchronous active-high reset, clears all tokens in flight
//   in_start : a block enters the pipeline this cycle
//   emerge   : the block started LATENCY edges earlier is valid at the pipeline output
module idct_latency_tracker #(
  parameter int unsigned LATENCY = 29
) (
  input  logic clk,
  input  logic rst,
  input  logic in_start,
  output logic emerge
);

  logic [LATENCY-1:0] pipe_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pipe_q <= '0;
    end else begin
      pipe_q[0] <= in_start;
      for (int unsigned i = 1; i < LATENCY; i++) begin
        pipe_q[i] <= pipe_q[i-1];
      end
    end
  end

  assign emerge = pipe_q[LATENCY-1];

endmodule

// File: rtl/idct_block_unloader.sv
// Output-side companion of the IDCT core.
// Captures the 64 parallel IDCT outputs when a tracked block emerges, then streams them in
// raster order over valid/ready, optionally level-shifted and clamped to 8-bit pixels.
//   clk, rst           : clock and asynchronous active-high reset
//   in_start           : block presented at the IDCT inputs this cycle
//   in0..in63          : IDCT parallel outputs
//   out_data/out_index : current sample and its raster index (registered index + buffer)
//   out_last           : current sample is index 63
//   out_valid/out_ready: stream handshake
//   busy               : capture buffer holds a block being streamed
//   drop_count         : saturating count of blocks lost because the buffer was busy
module idct_block_unloader
  import idct_pkg::*;
#(
  parameter int unsigned LATENCY     = 29,
  parameter bit          LEVEL_SHIFT = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_start,
  input  logic signed [WORD_W-1:0] in0,  in1,  in2,  in3,  in4,  in5,  in6,  in7,
                                   in8,  in9,  in10, in11, in12, in13, in14, in15,
                                   in16, in17, in18, in19, in20, in21, in22, in23,
                                   in24, in25, in26, in27, in28, in29, in30, in31,
                                   in32, in33, in34, in35, in36, in37, in38, in39,
                                   in40, in41, in42, in43, in44, in45, in46, in47,
                                   in48, in49, in50, in51, in52, in53, in54, in55,
                                   in56, in57, in58, in59, in60, in61, in62, in63,
  output logic        [WORD_W-1:0] out_data,
  output logic        [IDX_W-1:0]  out_index,
  output logic                     out_last,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     busy,
  output logic        [7:0]        drop_count
);

  unloader_state_e  state_q;
  logic [IDX_W-1:0] idx_q;
  logic [7:0]       drop_q;
  idct_block_t      blk_q;

  idct_block_t in_blk;
  idct_word_t  cur_word;
  logic        emerge;
  logic        xfer;
  logic        last_xfer;
  logic        capture;
  logic        drop;

  assign in_blk = {in63, in62, in61, in60, in59, in58, in57, in56,
                   in55, in54, in53, in52, in51, in50, in49, in48,
                   in47, in46, in45, in44, in43, in42, in41, in40,
                   in39, in38, in37, in36, in35, in34, in33, in32,
                   in31, in30, in29, in28, in27, in26, in25, in24,
                   in23, in22, in21, in20, in19, in18, in17, in16,
                   in15, in14, in13, in12, in11, in10, in9,  in8,
                   in7,  in6,  in5,  in4,  in3,  in2,  in1,  in0};

  idct_latency_tracker #(
    .LATENCY (LATENCY)
  ) u_tracker (
    .clk      (clk),
    .rst      (rst),
    .in_start (in_start),
    .emerge   (emerge)
  );

  always_comb begin
    xfer      = (state_q == StStream) && out_ready;
    last_xfer = xfer && (idx_q == IDX_LAST);
    // The buffer frees up on the same edge the final sample leaves, so a block emerging
    // then is taken without a bubble.
    capture   = emerge && ((state_q == StIdle) || last_xfer);
    drop      = emerge && (state_q == StStream) && !last_xfer;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      idx_q   <= '0;
      drop_q  <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (emerge) begin
            state_q <= StStream;
            idx_q   <= '0;
          end
        end
        StStream: begin
          if (xfer) begin
            // 63 wraps to 0, which is also the start index of a back-to-back block.
            idx_q <= idx_q + 1'b1;
            if ((idx_q == IDX_LAST) && !emerge) begin
              state_q <= StIdle;
            end
          end
          if (drop && (drop_q != 8'hff)) begin
            drop_q <= drop_q + 8'd1;
          end
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  // Data-only storage; it is never observed until a capture has filled it.
  always_ff @(posedge clk) begin
    if (capture) begin
      blk_q <= in_blk;
    end
  end

  always_comb begin
    cur_word   = idct_word_t'(blk_q[idx_q]);
    out_valid  = (state_q == StStream);
    busy       = out_valid;
    out_index  = idx_q;
    out_last   = out_valid && (idx_q == IDX_LAST);
    drop_count = drop_q;
    out_data   = '0;
    if (out_valid) begin
      out_data = LEVEL_SHIFT ? {8'h00, pixel_clamp(cur_word)} : cur_word;
    end
  end

endmodule
